fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 117 +++++++++++
 tb/tb_fetch_stage.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with direct-mapped BTB and 2-bit counters
module fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirectValid,
  input  logic [31:0] redirectPc,
  input  logic        bpUpdateValid,
  input  logic [31:0] bpUpdatePc,
  input  logic        bpUpdateTaken,
  input  logic [31:0] bpUpdateTarget,
  output logic [31:0] imemAddr,
  input  logic [31:0] imemData,
  output logic        outValid,
  output logic [31:0] outPc,
  output logic [31:0] outInstruction,
  output logic        outPredTaken,
  output logic [31:0] outPredTarget
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [31:0]            pc_q;
  logic [31:0]            pc_d;
  logic [31:0]            pc_plus4;

  logic [BTB_ENTRIES-1:0] btb_valid_q;
  logic [TAG_W-1:0]       btb_tag_q    [BTB_ENTRIES];
  logic [31:0]            btb_target_q [BTB_ENTRIES];
  logic [1:0]             btb_ctr_q    [BTB_ENTRIES];

  logic [IDX_W-1:0]       lk_idx;
  logic [TAG_W-1:0]       lk_tag;
  logic                   pred_taken;
  logic [31:0]            pred_target;

  logic [IDX_W-1:0]       up_idx;
  logic [TAG_W-1:0]       up_tag;
  logic                   up_hit;

  // Low address bits of the redirect and update PCs are architecturally ignored.
  logic                   unused_low_bits;
  assign unused_low_bits = ^{redirectPc[1:0], bpUpdatePc[1:0]};

  assign pc_plus4 = pc_q + 32'd4;

  // BTB lookup on the current PC; reads old contents even when an update targets the same entry.
  assign lk_idx      = pc_q[IDX_W+1:2];
  assign lk_tag      = pc_q[31:IDX_W+2];
  assign pred_taken  = btb_valid_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag) && btb_ctr_q[lk_idx][1];
  assign pred_target = pred_taken ? btb_target_q[lk_idx] : pc_plus4;

  assign up_idx = bpUpdatePc[IDX_W+1:2];
  assign up_tag = bpUpdatePc[31:IDX_W+2];
  assign up_hit = btb_valid_q[up_idx] && (btb_tag_q[up_idx] == up_tag);

  // Fetch is zero-latency; flush only squashes what is handed to decode, not the memory address.
  assign imemAddr       = pc_q;
  assign outValid       = !flush;
  assign outPc          = flush ? 32'd0 : pc_q;
  assign outInstruction = flush ? 32'd0 : imemData;
  assign outPredTaken   = flush ? 1'b0  : pred_taken;
  assign outPredTarget  = flush ? 32'd0 : pred_target;

  // Next-PC selection: redirect beats stall, stall beats prediction, prediction beats sequential.
  always_comb begin
    pc_d = pc_plus4;
    if (redirectValid) begin
      pc_d = {redirectPc[31:2], 2'b00};
    end else if (stall) begin
      pc_d = pc_q;
    end else if (pred_taken) begin
      pc_d = pred_target;
    end
  end

  // PC register; reset overrides any redirect presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= {RESET_PC[31:2], 2'b00};
    end else begin
      pc_q <= pc_d;
    end
  end

  // BTB training; independent of stall/flush/redirect, but dropped while in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      btb_valid_q <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_ctr_q[i] <= 2'b00;
      end
    end else if (bpUpdateValid) begin
      if (up_hit) begin
        if (bpUpdateTaken) begin
          btb_target_q[up_idx] <= bpUpdateTarget;
          if (btb_ctr_q[up_idx] != 2'b11) begin
            btb_ctr_q[up_idx] <= btb_ctr_q[up_idx] + 2'b01;
          end
        end else if (btb_ctr_q[up_idx] != 2'b00) begin
          btb_ctr_q[up_idx] <= btb_ctr_q[up_idx] - 2'b01;
        end
      end else if (bpUpdateTaken) begin
        btb_valid_q[up_idx]  <= 1'b1;
        btb_tag_q[up_idx]    <= up_tag;
        btb_target_q[up_idx] <= bpUpdateTarget;
        btb_ctr_q[up_idx]    <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - table-driven scoreboard bench for fetch_stage
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic        bpUpdateValid;
  logic [31:0] bpUpdatePc;
  logic        bpUpdateTaken;
  logic [31:0] bpUpdateTarget;
  logic [31:0] imemAddr;
  logic [31:0] imemData;
  logic        outValid;
  logic [31:0] outPc;
  logic [31:0] outInstruction;
  logic        outPredTaken;
  logic [31:0] outPredTarget;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .redirectValid  (redirectValid),
    .redirectPc     (redirectPc),
    .bpUpdateValid  (bpUpdateValid),
    .bpUpdatePc     (bpUpdatePc),
    .bpUpdateTaken  (bpUpdateTaken),
    .bpUpdateTarget (bpUpdateTarget),
    .imemAddr       (imemAddr),
    .imemData       (imemData),
    .outValid       (outValid),
    .outPc          (outPc),
    .outInstruction (outInstruction),
    .outPredTaken   (outPredTaken),
    .outPredTarget  (outPredTarget)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        flush;
    logic        rv;
    logic [31:0] rpc;
    logic        bv;
    logic [31:0] bpc;
    logic        bt;
    logic [31:0] btgt;
    logic [31:0] imem;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_pt;
    logic [31:0] e_tgt;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Builds one vector; flush squashing of the decode-side fields is applied here.
  function automatic vec_t mk(input logic r, input logic s, input logic f,
                              input logic rv, input logic [31:0] rpc,
                              input logic bv, input logic [31:0] bpc, input logic bt,
                              input logic [31:0] btgt, input logic [31:0] imem,
                              input logic [31:0] addr, input logic pt, input logic [31:0] tgt);
    vec_t v;
    v.rst = r; v.stall = s; v.flush = f; v.rv = rv; v.rpc = rpc;
    v.bv = bv; v.bpc = bpc; v.bt = bt; v.btgt = btgt; v.imem = imem;
    v.e_addr  = addr;
    v.e_valid = !f;
    v.e_pc    = f ? 32'd0 : addr;
    v.e_instr = f ? 32'd0 : imem;
    v.e_pt    = f ? 1'b0  : pt;
    v.e_tgt   = f ? 32'd0 : tgt;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL vec%0d %s: got %08h expected %08h", idx, name, act, exp);
    end
  endtask

  initial begin
    vec_t v;
    vec_t e;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirectValid = 1'b0; redirectPc = '0;
    bpUpdateValid = 1'b0; bpUpdatePc = '0; bpUpdateTaken = 1'b0; bpUpdateTarget = '0;
    imemData = '0;

    //                rst s  f  rv rpc            bv bpc       bt btgt      imem           addr           pt tgt
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,  0, 32'h0,   32'h1111_0000, 32'h0000_0000, 0, 32'h0000_0004));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,  0, 32'h0,   32'h1111_0001, 32'h0000_0004, 0, 32'h0000_0008));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,  0, 32'h0,   32'h1111_0002, 32'h0000_0008, 0, 32'h0000_000C));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,  0, 32'h0,   32'h1111_0003, 32'h0000_000C, 0, 32'h0000_0010));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,  0, 32'h0,   32'h2222_0000, 32'h0000_0010, 0, 32'h0000_0014));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,  0, 32'h0,   32'h2222_0001, 32'h0000_0010, 0, 32'h0000_0014));
    tbl.push_back(mk(0, 1, 0, 1, 32'h103,      0, 32'h0,  0, 32'h0,   32'h2222_0002, 32'h0000_0010, 0, 32'h0000_0014));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        1, 32'h20, 1, 32'h80,  32'h3333_0000, 32'h0000_0100, 0, 32'h0000_0104));
    tbl.push_back(mk(0, 0, 0, 1, 32'h20,       0, 32'h0,  0, 32'h0,   32'h3333_0001, 32'h0000_0104, 0, 32'h0000_0108));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        1, 32'h20, 0, 32'h0,   32'h3333_0002, 32'h0000_0020, 1, 32'h0000_0080));
    tbl.push_back(mk(0, 0, 0, 1, 32'h20,       1, 32'h20, 0, 32'h0,   32'h3333_0003, 32'h0000_0080, 0, 32'h0000_0084));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        1, 32'h44, 0, 32'h0,   32'h3333_0004, 32'h0000_0020, 0, 32'h0000_0024));
    tbl.push_back(mk(0, 0, 0, 1, 32'h44,       0, 32'h0,  0, 32'h0,   32'h3333_0005, 32'h0000_0024, 0, 32'h0000_0028));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,  0, 32'h0,   32'h3333_0006, 32'h0000_0044, 0, 32'h0000_0048));
    tbl.push_back(mk(0, 0, 1, 0, 32'h0,        0, 32'h0,  0, 32'h0,   32'hDEAD_BEEF, 32'h0000_0048, 0, 32'h0000_004C));
    tbl.push_back(mk(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0,   32'h4444_0000, 32'h0000_004C, 0, 32'h0000_0050));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,  0, 32'h0,   32'h4444_0001, 32'hFFFF_FFFC, 0, 32'h0000_0000));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        1, 32'h20, 1, 32'h90,  32'h4444_0002, 32'h0000_0000, 0, 32'h0000_0004));
    tbl.push_back(mk(0, 0, 0, 1, 32'h20,       1, 32'h20, 1, 32'h90,  32'h4444_0003, 32'h0000_0004, 0, 32'h0000_0008));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,        1, 32'h20, 1, 32'h90,  32'h5555_0000, 32'h0000_0020, 1, 32'h0000_0090));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        1, 32'h20, 0, 32'h0,   32'h5555_0001, 32'h0000_0020, 1, 32'h0000_0090));
    tbl.push_back(mk(0, 0, 0, 1, 32'h20,       0, 32'h0,  0, 32'h0,   32'h5555_0002, 32'h0000_0090, 0, 32'h0000_0094));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,  0, 32'h0,   32'h5555_0003, 32'h0000_0020, 1, 32'h0000_0090));
    tbl.push_back(mk(1, 0, 0, 1, 32'h40,       1, 32'h90, 1, 32'h200, 32'h6666_0000, 32'h0000_0090, 0, 32'h0000_0094));
    tbl.push_back(mk(0, 0, 0, 1, 32'h90,       0, 32'h0,  0, 32'h0,   32'h6666_0001, 32'h0000_0000, 0, 32'h0000_0004));
    tbl.push_back(mk(0, 0, 0, 1, 32'h20,       0, 32'h0,  0, 32'h0,   32'h6666_0002, 32'h0000_0090, 0, 32'h0000_0094));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,  0, 32'h0,   32'h6666_0003, 32'h0000_0020, 0, 32'h0000_0024));
    tbl.push_back(mk(0, 1, 1, 0, 32'h0,        0, 32'h0,  0, 32'h0,   32'h6666_0004, 32'h0000_0024, 0, 32'h0000_0028));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,  0, 32'h0,   32'h6666_0005, 32'h0000_0024, 0, 32'h0000_0028));

    repeat (2) @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      @(negedge clk);
      rst            = v.rst;
      stall          = v.stall;
      flush          = v.flush;
      redirectValid  = v.rv;
      redirectPc     = v.rpc;
      bpUpdateValid  = v.bv;
      bpUpdatePc     = v.bpc;
      bpUpdateTaken  = v.bt;
      bpUpdateTarget = v.btgt;
      imemData       = v.imem;
      sb.push_back(v);
      #1;
      e = sb.pop_front();
      n_vec++;
      chk("imemAddr",       i, imemAddr,              e.e_addr);
      chk("outValid",       i, {31'd0, outValid},     {31'd0, e.e_valid});
      chk("outPc",          i, outPc,                 e.e_pc);
      chk("outInstruction", i, outInstruction,        e.e_instr);
      chk("outPredTaken",   i, {31'd0, outPredTaken}, {31'd0, e.e_pt});
      chk("outPredTarget",  i, outPredTarget,         e.e_tgt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
